// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler with packet lock that shares one uart_transmitter
// among N_REQ byte-stream requesters.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int IDW          = 2,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 uart_tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 locked
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    lock_cnt;
  logic             last_q;

  logic [N_REQ-1:0] valid_rot;
  logic             owner_valid;
  logic             cand_found;
  logic [IDW-1:0]   cand;
  logic [7:0]       cand_data;
  logic             cand_last;
  logic             accept;
  logic [IDW-1:0]   grant_inc;

  function automatic logic [IDW-1:0] ptr_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return IDW'(sum);
  endfunction

  // Bit k of valid_rot is requester (rr_ptr + k) mod N_REQ.
  assign valid_rot = N_REQ'({req_valid, req_valid} >> rr_ptr);
  assign grant_inc = ptr_add(grant_id, 1);
  assign accept    = (state == IDLE) && !uart_tx_busy && cand_found;

  always_comb begin
    owner_valid = 1'b0;
    cand_found  = 1'b0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_valid = (IDW'(i) == grant_id) ? req_valid[i] : owner_valid;
    end
    if (locked) begin
      cand_found = owner_valid;
      cand       = grant_id;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand       = valid_rot[k] ? ptr_add(rr_ptr, k) : cand;
        cand_found = cand_found | valid_rot[k];
      end
    end
  end

  always_comb begin
    cand_data = 8'h00;
    cand_last = 1'b0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_data    = (IDW'(i) == cand) ? req_data[8*i +: 8] : cand_data;
      cand_last    = (IDW'(i) == cand) ? req_last[i] : cand_last;
      req_ready[i] = accept && (IDW'(i) == cand);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = accept ? LAUNCH : IDLE;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: state_next = uart_tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_next = uart_tx_busy ? WAIT_DONE : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Lock is released either by a last byte completing or by an owner that stays idle too long.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      locked   <= 1'b0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      state <= state_next;
      tx_en <= accept;
      if (accept) begin
        tx_data  <= cand_data;
        grant_id <= cand;
        last_q   <= cand_last;
        lock_cnt <= '0;
      end else if ((state == IDLE) && locked && !owner_valid) begin
        if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          locked   <= 1'b0;
          rr_ptr   <= grant_inc;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + CW'(1);
        end
      end
      if ((state == WAIT_DONE) && !uart_tx_busy) begin
        locked <= !last_q;
        if (last_q) begin
          rr_ptr <= grant_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios and random
// traffic against a transaction-level arbitration model plus a serial scoreboard.
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LT  = 8;
  localparam int CPB = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic [IDW-1:0] grant_id;
  logic           locked;

  logic           u_busy = 1'b0;
  logic [9:0]     u_sh   = 10'h3FF;
  int             u_cnt  = 0;
  logic           u_line;

  int             n_checks = 0;
  int             n_errors = 0;
  logic [7:0]     sb[$];

  uart_tx_scheduler #(.N_REQ(N), .IDW(IDW), .LOCK_TIMEOUT(LT)) dut (
    .sys_clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
    .uart_tx_busy(u_busy), .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  // Simple UART transmitter: start bit, 8 data bits LSB first, stop bit, CPB clocks per bit.
  always @(posedge clk) begin
    if (!u_busy) begin
      if (tx_en) begin
        u_sh   <= {1'b1, tx_data, 1'b0};
        u_busy <= 1'b1;
        u_cnt  <= 0;
      end
    end else if (u_cnt == 10*CPB - 1) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else begin
      u_cnt <= u_cnt + 1;
    end
  end
  assign u_line = u_busy ? u_sh[u_cnt / CPB] : 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int id);
    id = -1;
    for (int c = 0; c < 300 && id < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) id = i;
    end
  endtask

  // Returns at the first negedge where busy is low again after having risen.
  task automatic wait_tx_done(output logic ok);
    int c;
    c = 0;
    while (!u_busy && c < 100) begin @(negedge clk); c++; end
    while (u_busy && c < 200) begin @(negedge clk); c++; end
    ok = !u_busy && (c < 200);
  endtask

  // Serial decoder feeding the byte scoreboard.
  initial begin
    logic [7:0] b;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (u_line === 1'b0) begin
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          b[j] = u_line;
        end
        repeat (CPB) @(negedge clk);
        chk("serial_stop", u_line, 1);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL serial_extra: decoded 0x%0h with no accepted byte pending", b);
        end else begin
          exp_b = sb.pop_front();
          chk("serial_byte", b, exp_b);
        end
      end
    end
  end

  // Transaction-level model: one byte in flight at a time, round-robin with packet lock.
  initial begin
    bit         m_init = 0, m_inflight = 0, m_seen = 0, m_locked = 0;
    bit         m_last = 0, m_launch = 0, was_launch;
    int         m_owner = 0, m_ptr = 0, m_cnt = 0, c;
    logic [7:0] m_txd = 8'h00;
    logic [N-1:0] exp_ready;
    forever begin
      @(negedge clk);
      c = -1;
      if (!m_inflight && !u_busy) begin
        if (m_locked) begin
          if (req_valid[m_owner]) c = m_owner;
        end else begin
          for (int k = N - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % N]) c = (m_ptr + k) % N;
        end
      end
      if (m_init) begin
        exp_ready = '0;
        if (c >= 0) exp_ready[c] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("tx_en", tx_en, m_launch);
        chk("tx_data", tx_data, m_txd);
        chk("grant_id", grant_id, m_owner);
        chk("locked", locked, m_locked);
      end
      if (rst) begin
        m_init = 1; m_inflight = 0; m_seen = 0; m_locked = 0; m_last = 0;
        m_launch = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_txd = 8'h00;
      end else if (m_init) begin
        was_launch = m_launch;
        m_launch = 0;
        if (c >= 0) begin
          m_inflight = 1; m_seen = 0; m_owner = c; m_cnt = 0; m_launch = 1;
          m_txd  = req_data[8*c +: 8];
          m_last = req_last[c];
          sb.push_back(m_txd);
        end else if (m_inflight) begin
          if (!was_launch && u_busy) begin
            m_seen = 1;
          end else if (m_seen && !u_busy) begin
            m_inflight = 0;
            m_locked   = !m_last;
            if (m_last) m_ptr = (m_owner + 1) % N;
          end
        end else if (m_locked && !req_valid[m_owner]) begin
          m_cnt++;
          if (m_cnt == LT) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
            m_cnt    = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   id, n, c;
    int   exp_ids[5];
    logic ok, got;
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 2; exp_ids[3] = 3; exp_ids[4] = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);

    // Single byte from requester 0
    step();
    rst = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_tx_en", tx_en, 1);
    chk("t1_tx_data", tx_data, 8'h41);
    wait_tx_done(ok);
    chk("t1_done", ok, 1);
    @(negedge clk);
    chk("t1_locked", locked, 0);
    step();
    req_valid = 4'b0011; req_last = 4'b0011; req_data = $urandom;
    wait_accept(id);
    chk("t1_rr_ptr1", id, 1);
    step();
    req_valid = 4'b0000;
    wait_tx_done(ok);
    chk("t1b_done", ok, 1);

    // All requesters, single-byte packets
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; req_data = $urandom;
    for (int k = 0; k < 5; k++) begin
      wait_accept(id);
      chk("t2_order", id, exp_ids[k]);
      step();
      req_data = $urandom;
    end

    // Requester 1 holds the lock over a 3-byte packet
    req_valid = 4'b0111; req_last = 4'b0101;
    wait_accept(id);
    chk("t3_first", id, 1);
    step();
    req_data[15:8] = 8'h92; req_last[1] = 1'b0;
    wait_accept(id);
    chk("t3_second", id, 1);
    chk("t3_locked2", locked, 1);
    step();
    req_data[15:8] = 8'h93; req_last[1] = 1'b1;
    wait_accept(id);
    chk("t3_third", id, 1);
    chk("t3_locked3", locked, 1);
    step();
    wait_accept(id);
    chk("t3_next", id, 2);
    chk("t3_unlocked", locked, 0);

    // Requester 3 locks then goes quiet; requester 0 waits out the timeout
    step();
    req_valid = 4'b1000; req_last = 4'b0000;
    wait_accept(id);
    chk("t4_grant3", id, 3);
    step();
    req_valid = 4'b0001; req_last = 4'b0001; req_data[7:0] = 8'hC3;
    wait_tx_done(ok);
    chk("t4_done", ok, 1);
    n = 0; got = 1'b0;
    while (!got && n < LT + 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("t4_locked_hold", locked, 1);
      if (req_ready != 4'b0000) got = 1'b1;
    end
    chk("t4_wait_cycles", n, LT + 1);
    chk("t4_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t4_grant0", grant_id, 0);
    chk("t4_unlocked", locked, 0);
    chk("t4_tx_data", tx_data, 8'hC3);

    // Reset while the UART is still busy
    step();
    req_valid = 4'b0010; req_last = 4'b0010; req_data[15:8] = 8'h77;
    wait_accept(id);
    chk("t5_grant1", id, 1);
    step();
    req_valid = 4'b0100; req_last = 4'b0100; req_data[23:16] = 8'h5A;
    c = 0;
    while (!u_busy && c < 50) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_tx_en", tx_en, 0);
    chk("t5_tx_data", tx_data, 8'h00);
    chk("t5_ready_busy", req_ready, 4'b0000);
    chk("t5_grant", grant_id, 0);
    chk("t5_locked", locked, 0);
    c = 0;
    while (u_busy && c < 100) begin @(negedge clk); c++; end
    chk("t5_ready_after", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_launch", tx_en, 1);
    chk("t5_launch_data", tx_data, 8'h5A);

    // Random traffic with occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = N'($urandom) & N'($urandom_range(0, 3) == 0 ? 4'h0 : 4'hF);
        req_last  = N'($urandom);
        req_data  = $urandom;
      end
    end
    step();
    rst = 1'b0; req_valid = 4'b0000;
    c = 0;
    while ((sb.size() != 0 || u_busy) && c < 600) begin @(negedge clk); c++; end
    chk("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
